// File: rtl/kyber_decode_pkg.sv
// Shared types and constants for the streaming ByteDecode_d controller.
package kyber_decode_pkg;

    localparam int ELL_MAX    = 12;
    localparam int NUM_COEFFS = 256;
    localparam int ACC_W      = ELL_MAX + 7;
    localparam int BIT_CNT_W  = $clog2(ACC_W + 1);
    localparam int BYTE_CNT_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [BYTE_CNT_W-1:0] bytes_for_ell(input logic [3:0] ell);
        return {ell, 5'b00000};
    endfunction

    function automatic logic ell_legal(input logic [3:0] ell);
        return (ell != 4'd0) && (ell <= 4'(ELL_MAX));
    endfunction

endpackage

// File: rtl/byte_decode_stream_ctrl_bit_accumulator.sv
// LSB-first bit accumulator: bytes are pushed in above the valid bits,
// coefficients are popped from the bottom.
module bit_accumulator
    import kyber_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [7:0]           byte_i,
    input  logic                 pop_i,
    input  logic [3:0]           ell_i,
    output logic [ELL_MAX-1:0]   coeff_o,
    output logic [BIT_CNT_W-1:0] bit_cnt_o,
    output logic                 avail_o
);

    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        if (clear_i) begin
            acc_d     = '0;
            bit_cnt_d = '0;
        end else if (push_i) begin
            // bit_cnt < ell <= 12 on a push, so the shifted byte always fits.
            acc_d     = acc_q | (ACC_W'(byte_i) << bit_cnt_q);
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(8);
        end else if (pop_i) begin
            acc_d     = acc_q >> ell_i;
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(ell_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign coeff_o   = acc_q[ELL_MAX-1:0];
    assign bit_cnt_o = bit_cnt_q;
    assign avail_o   = (bit_cnt_q >= BIT_CNT_W'(ell_i));

endmodule

// File: rtl/byte_decode_stream_ctrl.sv
// Streaming ByteDecode_d (d = 1..12): one byte in or one d-bit coefficient
// out per cycle, 256 coefficients per polynomial.
module byte_decode_stream_ctrl
    import kyber_decode_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         ell,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    output logic               in_ready,
    output logic               out_valid,
    output logic [ELL_MAX-1:0] out_coeff,
    output logic [7:0]         out_idx,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e                state_q, state_d;
    logic [3:0]            ell_q, ell_d;
    logic [7:0]            coeff_cnt_q, coeff_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  err_q, err_d;

    logic                  run;
    logic                  start_ok;
    logic                  abort_run;
    logic                  push;
    logic                  pop;
    logic                  avail;
    logic [ELL_MAX-1:0]    acc_coeff;
    logic [ELL_MAX-1:0]    coeff_mask;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign run       = (state_q == RUN);
    assign start_ok  = (state_q == IDLE) && start && ell_legal(ell);
    assign abort_run = run && abort;

    // Push and pop are mutually exclusive: one needs bit_cnt < ell, the other bit_cnt >= ell.
    assign in_ready  = run && (bit_cnt < BIT_CNT_W'(ell_q)) && (byte_cnt_q < bytes_for_ell(ell_q));
    assign out_valid = run && avail;
    assign push      = in_valid && in_ready && !abort;
    assign pop       = out_valid && out_ready && !abort;

    bit_accumulator u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (start_ok || abort_run),
        .push_i    (push),
        .byte_i    (in_byte),
        .pop_i     (pop),
        .ell_i     (ell_q),
        .coeff_o   (acc_coeff),
        .bit_cnt_o (bit_cnt),
        .avail_o   (avail)
    );

    for (genvar gi = 0; gi < ELL_MAX; gi++) begin : g_mask
        assign coeff_mask[gi] = (4'(gi) < ell_q);
    end

    always_comb begin
        state_d     = state_q;
        ell_d       = ell_q;
        coeff_cnt_d = coeff_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ell_legal(ell)) begin
                        ell_d       = ell;
                        coeff_cnt_d = '0;
                        byte_cnt_d  = '0;
                        state_d     = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    coeff_cnt_d = '0;
                    byte_cnt_d  = '0;
                    state_d     = IDLE;
                end else begin
                    if (push) begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    end
                    if (pop) begin
                        coeff_cnt_d = coeff_cnt_q + 8'd1;
                        if (coeff_cnt_q == 8'(NUM_COEFFS - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ell_q       <= '0;
            coeff_cnt_q <= '0;
            byte_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ell_q       <= ell_d;
            coeff_cnt_q <= coeff_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            err_q       <= err_d;
        end
    end

    assign out_coeff = run ? (acc_coeff & coeff_mask) : '0;
    assign out_idx   = run ? coeff_cnt_q : 8'd0;
    assign busy      = run;
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_byte_decode_stream_ctrl.sv
// Directed self-checking bench for byte_decode_stream_ctrl.
module tb_byte_decode_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  ell;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_coeff;
    logic [7:0]  out_idx;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] stream_mem [0:383];

    byte_decode_stream_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ell       (ell),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_coeff (out_coeff),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Coefficient k of ByteDecode_d over stream_mem, bits taken LSB-first.
    function automatic int exp_coeff(input int k, input int d);
        int         v;
        int         p;
        logic [7:0] byt;
        v = 0;
        for (int b = 0; b < d; b++) begin
            p = k * d + b;
            if (p < 3072) begin
                byt = stream_mem[p / 8];
                if (byt[p % 8]) v = v | (1 << b);
            end
        end
        return v;
    endfunction

    task automatic fill(input int kind);
        for (int i = 0; i < 384; i++) begin
            case (kind)
                0:       stream_mem[i] = (i % 3 == 0) ? 8'h01 : ((i % 3 == 1) ? 8'h20 : 8'h00);
                1:       stream_mem[i] = 8'hA5;
                2:       stream_mem[i] = 8'(i * 37 + 11);
                3:       stream_mem[i] = 8'(i * 91 + 200);
                default: stream_mem[i] = 8'((i * 13) ^ 90);
            endcase
        end
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        ell       = 4'd0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
    endtask

    // Starts a polynomial and streams stream_mem with both sides always ready.
    task automatic run_stream(input int d, input int stop_after,
                              output int pops, output int bad, output int bytes,
                              output int dones, output int done_gap, output bit timeout,
                              output int c0, output int c1);
        int cyc;
        int last_pop;
        int done_cyc;
        cyc = 0; last_pop = -100; done_cyc = -1;
        pops = 0; bad = 0; bytes = 0; dones = 0; done_gap = -1; timeout = 1'b0;
        c0 = -1; c1 = -1;
        @(negedge clk);
        start = 1'b1; ell = 4'(d); out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (1) begin
            if (done) begin
                dones++;
                done_gap = cyc - last_pop;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (pops == 0) c0 = int'(out_coeff);
                if (pops == 1) c1 = int'(out_coeff);
                if (pops >= 256 || out_idx !== 8'(pops) || out_coeff !== 12'(exp_coeff(pops, d))) begin
                    bad++;
                    if (bad <= 3)
                        $display("  beat %0d: got idx=%0d coeff=%03h, required idx=%0d coeff=%03h",
                                 pops, out_idx, out_coeff, pops, exp_coeff(pops, d));
                end
                pops++;
                last_pop = cyc;
            end
            if (pops == stop_after) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (cyc > 4000) begin
                timeout = 1'b1;
                break;
            end
            in_valid = 1'b1;
            in_byte  = stream_mem[(bytes < 384) ? bytes : 383];
            if (in_ready) bytes++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        $display("stream d=%0d pops=%0d bytes=%0d dones=%0d bad=%0d", d, pops, bytes, dones, bad);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, out_valid, in_ready, done, err, out_coeff, out_idx} !== 25'd0) begin
            n_mis++;
            $display("FAIL reset_outputs: got %h required 0", {busy, out_valid, in_ready, done, err, out_coeff, out_idx});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, out_valid, in_ready, done, err} !== 5'd0) begin
            n_mis++;
            $display("FAIL post_reset_idle: got %b required 00000", {busy, out_valid, in_ready, done, err});
        end
    endtask

    task automatic test_ell12();
        int pops, bad, bytes, dones, gap, c0, c1;
        bit to;
        fill(0);
        run_stream(12, -1, pops, bad, bytes, dones, gap, to, c0, c1);
        n_cmp++;
        if (to !== 1'b0) begin n_mis++; $display("FAIL ell12_timeout: got %0d required 0", to); end
        n_cmp++;
        if (c0 !== 1 || c1 !== 2) begin n_mis++; $display("FAIL ell12_first: got %h,%h required 001,002", c0, c1); end
        n_cmp++;
        if (pops !== 256) begin n_mis++; $display("FAIL ell12_beats: got %0d required 256", pops); end
        n_cmp++;
        if (bad !== 0) begin n_mis++; $display("FAIL ell12_coeffs: got %0d bad beats required 0", bad); end
        n_cmp++;
        if (bytes !== 384) begin n_mis++; $display("FAIL ell12_bytes: got %0d required 384", bytes); end
        n_cmp++;
        if (dones !== 1 || gap !== 1) begin
            n_mis++;
            $display("FAIL ell12_done: got count=%0d gap=%0d required count=1 gap=1", dones, gap);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_mis++; $display("FAIL ell12_idle_after: got busy=%b required 0", busy); end
    endtask

    task automatic test_ell1();
        int pops, bad, bytes, dones, gap, c0, c1;
        bit to;
        fill(1);
        run_stream(1, -1, pops, bad, bytes, dones, gap, to, c0, c1);
        n_cmp++;
        if (c0 !== 1 || c1 !== 0) begin n_mis++; $display("FAIL ell1_first: got %0d,%0d required 1,0", c0, c1); end
        n_cmp++;
        if (pops !== 256 || bad !== 0 || to !== 1'b0) begin
            n_mis++;
            $display("FAIL ell1_stream: got pops=%0d bad=%0d to=%0d required 256/0/0", pops, bad, to);
        end
        n_cmp++;
        if (bytes !== 32 || dones !== 1) begin
            n_mis++;
            $display("FAIL ell1_bytes_done: got bytes=%0d dones=%0d required 32/1", bytes, dones);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        start = 1'b1; ell = 4'd4; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_byte = 8'h3C;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL stall_ready: got in_ready=%b busy=%b required 1/1", in_ready, busy);
        end
        @(negedge clk);
        in_byte = 8'h00;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_coeff !== 12'h00C || out_idx !== 8'd0 || in_ready !== 1'b0) begin
                n_mis++;
                $display("FAIL stall_hold%0d: got v=%b c=%h i=%0d r=%b required 1/00c/0/0",
                         i, out_valid, out_coeff, out_idx, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_coeff !== 12'h003 || out_idx !== 8'd1) begin
            n_mis++;
            $display("FAIL stall_next: got v=%b c=%h i=%0d required 1/003/1", out_valid, out_coeff, out_idx);
        end
        out_ready = 1'b0; in_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        $display("stall d=4 done");
    endtask

    task automatic test_illegal();
        int bad_ells [2] = '{0, 13};
        foreach (bad_ells[k]) begin
            @(negedge clk);
            start = 1'b1; ell = 4'(bad_ells[k]);
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
                n_mis++;
                $display("FAIL illegal_ell%0d: got err=%b busy=%b in_ready=%b required 1/0/0",
                         bad_ells[k], err, busy, in_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                n_mis++;
                $display("FAIL illegal_pulse%0d: got err=%b busy=%b required 0/0", bad_ells[k], err, busy);
            end
            $display("illegal start ell=%0d", bad_ells[k]);
        end
    endtask

    task automatic test_abort();
        int pops, bad, bytes, dones, gap, c0, c1;
        int done_seen;
        bit to;
        fill(2);
        run_stream(10, 100, pops, bad, bytes, dones, gap, to, c0, c1);
        n_cmp++;
        if (pops !== 100 || bad !== 0) begin
            n_mis++;
            $display("FAIL abort_prefix: got pops=%0d bad=%0d required 100/0", pops, bad);
        end
        @(negedge clk);
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({busy, out_valid, in_ready, done} !== 4'b0000 || out_idx !== 8'd0) begin
            n_mis++;
            $display("FAIL abort_idle: got b/v/r/d=%b idx=%0d required 0000/0", {busy, out_valid, in_ready, done}, out_idx);
        end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        n_cmp++;
        if (done_seen !== 0) begin n_mis++; $display("FAIL abort_no_done: got %0d required 0", done_seen); end
        fill(3);
        run_stream(10, -1, pops, bad, bytes, dones, gap, to, c0, c1);
        n_cmp++;
        if (pops !== 256 || bad !== 0 || bytes !== 320 || dones !== 1) begin
            n_mis++;
            $display("FAIL abort_fresh: got pops=%0d bad=%0d bytes=%0d dones=%0d required 256/0/320/1",
                     pops, bad, bytes, dones);
        end
    endtask

    task automatic test_async_reset();
        int pops, bad, bytes, dones, gap, c0, c1;
        bit to;
        fill(4);
        run_stream(11, 50, pops, bad, bytes, dones, gap, to, c0, c1);
        n_cmp++;
        if (pops !== 50 || bad !== 0) begin
            n_mis++;
            $display("FAIL arst_prefix: got pops=%0d bad=%0d required 50/0", pops, bad);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, out_valid, in_ready, done, err, out_coeff, out_idx} !== 25'd0) begin
            n_mis++;
            $display("FAIL arst_outputs: got %h required 0", {busy, out_valid, in_ready, done, err, out_coeff, out_idx});
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL arst_idle: got busy=%b in_ready=%b required 0/0", busy, in_ready);
        end
        run_stream(11, -1, pops, bad, bytes, dones, gap, to, c0, c1);
        n_cmp++;
        if (pops !== 256 || bad !== 0 || bytes !== 352 || dones !== 1 || to !== 1'b0) begin
            n_mis++;
            $display("FAIL arst_rerun: got pops=%0d bad=%0d bytes=%0d dones=%0d required 256/0/352/1",
                     pops, bad, bytes, dones);
        end
    endtask

    initial begin
        test_reset();
        test_ell12();
        test_ell1();
        test_stall();
        test_illegal();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
